uart_rx_deframer: RTL and testbench

- 8-bit UART receiver; the downstream peer of the 8N1 transmitter.
- Consumes the serial line from the other FPGA and recovers bytes by sampling each bit at mid-bit.
- Presents each good byte to the consuming logic with a one-cycle valid strobe, and flags framing errors.
- Frame format matches the transmitter: start bit 0, 8 data bits LSB first, stop bit 1, each bit CLKS_PER_BIT clocks long.

---
 rtl/uart_rx_deframer.sv | 214 +++++++++++++++++++++
 tb/tb_uart_rx_deframer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deframer.sv
// ---------------------------------------------------------------------------
// uart_rx_deframer
//
// 8-bit UART receiver for the 8N1 link coming from the peer FPGA. The serial
// line is brought into the clock domain through a 2-flop synchronizer. Each
// bit is then sampled at mid-bit by a small FSM. Good bytes are presented
// with a one-cycle valid strobe. A stop bit sampled as 0 produces a
// one-cycle framing error strobe.
//
// Optional feature: define UART_RX_PARITY_EN to add an even-parity bit
// between the last data bit and the stop bit. When it is defined:
//   - the o_Rx_Parity_Err output is present;
//   - on a parity mismatch, the valid strobe is suppressed.
//
// Parameters:
//   CLKS_PER_BIT    clocks per bit (clock frequency / baud), legal 4..256
//
// Ports:
//   i_Clock          in   system clock, all logic on posedge
//   i_Rst_n          in   asynchronous active-low reset
//   i_Rx_Serial      in   serial line (asynchronous, idles high)
//   o_Rx_DV          out  one-cycle pulse: o_Rx_Byte holds a new good byte
//   o_Rx_Byte        out  last good byte, changes only with o_Rx_DV
//   o_Rx_Frame_Err   out  one-cycle pulse: stop bit sampled as 0
//   o_Rx_Active      out  high from confirmed start bit to frame completion
//   o_Rx_Parity_Err  out  (UART_RX_PARITY_EN only) one-cycle pulse, aligned
//                         with the stop-bit sample, on even-parity mismatch
//
// Handshake: o_Rx_DV is a qualifier, not a valid/ready pair. The consumer
// cannot stall the receiver. It must capture o_Rx_Byte in the cycle o_Rx_DV
// is high, or accept that the byte may be overwritten by the next frame.
// ---------------------------------------------------------------------------
module uart_rx_deframer #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       i_Clock,
    input  logic       i_Rst_n,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_Frame_Err,
    output logic       o_Rx_Active
`ifdef UART_RX_PARITY_EN
    ,
    output logic       o_Rx_Parity_Err
`endif
);

    localparam logic [7:0] LAST_CNT = 8'(CLKS_PER_BIT - 1);
    localparam logic [7:0] HALF_CNT = 8'((CLKS_PER_BIT - 1) / 2);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        PARITY  = 3'd3,
        STOP    = 3'd4,
        CLEANUP = 3'd5
    } state_t;

    state_t     state;
    logic       rx_meta;
    logic       rx_s;
    logic [7:0] clk_cnt;
    logic [2:0] bit_idx;
    logic [7:0] shift_reg;

`ifdef UART_RX_PARITY_EN
    logic parity_bit;
    logic parity_bad;

    // Even parity: the XOR of the data bits and the parity bit must be 0.
    assign parity_bad = ^{shift_reg, parity_bit};
`endif

    // Two-flop synchronizer. Both flops reset to the idle-high line level so
    // that coming out of reset never looks like a start bit.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_Rx_Serial;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state          <= IDLE;
            clk_cnt        <= 8'd0;
            bit_idx        <= 3'd0;
            shift_reg      <= 8'h00;
            o_Rx_DV        <= 1'b0;
            o_Rx_Byte      <= 8'h00;
            o_Rx_Frame_Err <= 1'b0;
            o_Rx_Active    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bit      <= 1'b0;
            o_Rx_Parity_Err <= 1'b0;
`endif
        end else begin
            // Strobes are single-cycle; they are set only at the stop sample.
            o_Rx_DV        <= 1'b0;
            o_Rx_Frame_Err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            o_Rx_Parity_Err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    clk_cnt <= 8'd0;
                    bit_idx <= 3'd0;
                    if (!rx_s) begin
                        state <= START;
                    end
                end

                // Wait to the middle of the start bit. If the line is still
                // low there, the start bit is confirmed. Otherwise it was a
                // glitch and the FSM quietly returns to IDLE.
                START: begin
                    if (clk_cnt == HALF_CNT) begin
                        clk_cnt <= 8'd0;
                        if (!rx_s) begin
                            state       <= DATA;
                            o_Rx_Active <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 8'd1;
                    end
                end

                // Counting a full bit from mid-start lands every sample at
                // mid-bit. The LSB arrives first, so bits enter at the top
                // and shift right.
                DATA: begin
                    if (clk_cnt == LAST_CNT) begin
                        clk_cnt   <= 8'd0;
                        shift_reg <= {rx_s, shift_reg[7:1]};
                        if (bit_idx == 3'd7) begin
                            bit_idx <= 3'd0;
`ifdef UART_RX_PARITY_EN
                            state   <= PARITY;
`else
                            state   <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 8'd1;
                    end
                end

`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (clk_cnt == LAST_CNT) begin
                        clk_cnt    <= 8'd0;
                        parity_bit <= rx_s;
                        state      <= STOP;
                    end else begin
                        clk_cnt <= clk_cnt + 8'd1;
                    end
                end
`endif

                STOP: begin
                    if (clk_cnt == LAST_CNT) begin
                        clk_cnt     <= 8'd0;
                        o_Rx_Active <= 1'b0;
                        state       <= CLEANUP;
`ifdef UART_RX_PARITY_EN
                        o_Rx_Parity_Err <= parity_bad;
                        if (!rx_s) begin
                            o_Rx_Frame_Err <= 1'b1;
                        end else if (!parity_bad) begin
                            o_Rx_Byte <= shift_reg;
                            o_Rx_DV   <= 1'b1;
                        end
`else
                        if (rx_s) begin
                            o_Rx_Byte <= shift_reg;
                            o_Rx_DV   <= 1'b1;
                        end else begin
                            o_Rx_Frame_Err <= 1'b1;
                        end
`endif
                    end else begin
                        clk_cnt <= clk_cnt + 8'd1;
                    end
                end

                // Holding here until the line is high stops a break, or a
                // line stuck low, from being read as a stream of start bits.
                CLEANUP: begin
                    clk_cnt <= 8'd0;
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state       <= IDLE;
                    clk_cnt     <= 8'd0;
                    bit_idx     <= 3'd0;
                    o_Rx_Active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_deframer
//
// Directed bench for uart_rx_deframer with CLKS_PER_BIT=16.
//   - A vector table of frames (byte, stop bit, expected DV and framing
//     error) is applied in a loop.
//   - Hand-written sequences cover the multi-cycle corner cases:
//       * a start glitch;
//       * back-to-back frames;
//       * a line held low;
//       * reset in mid-frame;
//       * the parity build, when UART_RX_PARITY_EN is defined.
//   - A negedge monitor checks every DV against an expected-byte queue.
// ---------------------------------------------------------------------------
module tb_uart_rx_deframer;

    localparam int CPB = 16;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic       rx_dv;
    logic [7:0] rx_byte;
    logic       rx_ferr;
    logic       rx_active;
`ifdef UART_RX_PARITY_EN
    logic       rx_perr;
`endif

    uart_rx_deframer #(.CLKS_PER_BIT(CPB)) dut (
        .i_Clock        (clk),
        .i_Rst_n        (rst_n),
        .i_Rx_Serial    (rx),
        .o_Rx_DV        (rx_dv),
        .o_Rx_Byte      (rx_byte),
        .o_Rx_Frame_Err (rx_ferr),
        .o_Rx_Active    (rx_active)
`ifdef UART_RX_PARITY_EN
        ,
        .o_Rx_Parity_Err(rx_perr)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- bookkeeping ----------------
    int         checks   = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    logic [7:0] last_good = 8'h00;
    logic [7:0] prev_byte = 8'h00;
    int         dv_cnt = 0;
    int         ferr_cnt = 0;
    int         perr_cnt = 0;
    int         active_cnt = 0;
    int         dv_cyc = 0;
    int         start_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_byte = 8'h00;
        end else begin
            if (rx_active) active_cnt++;
            if (rx_ferr) ferr_cnt++;
`ifdef UART_RX_PARITY_EN
            if (rx_perr) perr_cnt++;
`endif
            if (rx_dv) begin
                dv_cnt++;
                dv_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL dv_unexpected: got byte 0x%0h expected no DV", rx_byte);
                end else begin
                    check("dv_byte", {24'd0, rx_byte}, {24'd0, exp_q.pop_front()});
                end
            end else if (rx_byte !== prev_byte) begin
                check("byte_changed_without_dv", {24'd0, rx_byte}, {24'd0, prev_byte});
            end
            if (rx_dv && rx_ferr) begin
                check("dv_and_ferr_same_cycle", 32'd1, 32'd0);
            end
            prev_byte = rx_byte;
        end
    end

    // ---------------- driver tasks ----------------
    // Caller stays aligned at posedge+#1; each bit is held CPB clocks.
    task automatic drive_bit(input logic b);
        rx = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip);
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ par_flip);
`else
        if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
        drive_bit(stop);
        rx = 1'b1;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_dv;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[5];

`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 10;
`else
    localparam int FRAME_BITS = 9;
`endif
    // Falling edge -> 2 sync flops -> IDLE exit -> half bit -> bits to mid-stop.
    localparam int EXP_LAT = 3 + 1 + (CPB - 1) / 2 + FRAME_BITS * CPB;

    task automatic run_vec(input vec_t v, input string tag);
        int dv0, fe0;
        dv0 = dv_cnt;
        fe0 = ferr_cnt;
        active_cnt = 0;
        if (v.exp_dv) begin
            exp_q.push_back(v.data);
            last_good = v.data;
        end
        send_frame(v.data, v.stop, 1'b0);
        idle_cycles(3 * CPB);
        check({tag, "_dv_count"}, dv_cnt - dv0, {31'd0, v.exp_dv});
        check({tag, "_ferr_count"}, ferr_cnt - fe0, {31'd0, v.exp_ferr});
        check({tag, "_byte"}, {24'd0, rx_byte}, {24'd0, last_good});
        check({tag, "_active_idle"}, {31'd0, rx_active}, 32'd0);
        if (v.exp_dv) begin
            check_range({tag, "_active_len"}, active_cnt, FRAME_BITS * CPB - 1, FRAME_BITS * CPB + 1);
            check_range({tag, "_latency"}, dv_cyc - start_cyc, EXP_LAT - 2, EXP_LAT + 2);
        end
    endtask

    initial begin
        vec_t bb;
        logic [7:0] d81;
        int dv0, fe0, pe0;

        vecs[0] = '{data: 8'hA5, stop: 1'b1, exp_dv: 1'b1, exp_ferr: 1'b0};
        vecs[1] = '{data: 8'h3C, stop: 1'b1, exp_dv: 1'b1, exp_ferr: 1'b0};
        vecs[2] = '{data: 8'h0F, stop: 1'b0, exp_dv: 1'b0, exp_ferr: 1'b1};
        vecs[3] = '{data: 8'hF0, stop: 1'b1, exp_dv: 1'b1, exp_ferr: 1'b0};
        vecs[4] = '{data: 8'h96, stop: 1'b1, exp_dv: 1'b1, exp_ferr: 1'b0};

        rx = 1'b1;
        rst_n = 1'b0;
        idle_cycles(4);
        check("reset_dv", {31'd0, rx_dv}, 32'd0);
        check("reset_byte", {24'd0, rx_byte}, 32'd0);
        check("reset_ferr", {31'd0, rx_ferr}, 32'd0);
        check("reset_active", {31'd0, rx_active}, 32'd0);
        rst_n = 1'b1;
        idle_cycles(2 * CPB);

        // Start glitch of 5 clocks: shorter than the half-bit confirmation.
        dv0 = dv_cnt;
        active_cnt = 0;
        rx = 1'b0;
        idle_cycles(5);
        rx = 1'b1;
        idle_cycles(3 * CPB);
        check("glitch_dv", dv_cnt - dv0, 32'd0);
        check("glitch_active", active_cnt, 32'd0);

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Back-to-back frames with no idle gap.
        dv0 = dv_cnt;
        bb.data = 8'h00;
        exp_q.push_back(8'h00);
        send_frame(8'h00, 1'b1, 1'b0);
        exp_q.push_back(8'hFF);
        send_frame(8'hFF, 1'b1, 1'b0);
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1, 1'b0);
        last_good = 8'h55;
        idle_cycles(3 * CPB);
        check("b2b_dv_count", dv_cnt - dv0, 32'd3);
        check("b2b_byte", {24'd0, rx_byte}, 32'h55);
        check("b2b_queue_empty", exp_q.size(), 32'd0);

        // Line held low for several frame times: exactly one framing error.
        dv0 = dv_cnt;
        fe0 = ferr_cnt;
        send_frame(8'h12, 1'b0, 1'b0);
        rx = 1'b0;
        idle_cycles(30 * CPB);
        check("held_low_ferr_count", ferr_cnt - fe0, 32'd1);
        check("held_low_dv_count", dv_cnt - dv0, 32'd0);
        rx = 1'b1;
        idle_cycles(3 * CPB);
        bb = '{data: 8'hC3, stop: 1'b1, exp_dv: 1'b1, exp_ferr: 1'b0};
        run_vec(bb, "after_break");

        // Reset in the middle of data bit 4 of 8'h81.
        dv0 = dv_cnt;
        fe0 = ferr_cnt;
        d81 = 8'h81;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d81[i]);
        rx = d81[4];
        idle_cycles(CPB / 2);
        check("midframe_active_before_reset", {31'd0, rx_active}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midframe_reset_active", {31'd0, rx_active}, 32'd0);
        check("midframe_reset_byte", {24'd0, rx_byte}, 32'd0);
        check("midframe_reset_dv", {31'd0, rx_dv}, 32'd0);
        last_good = 8'h00;
        rx = 1'b1;
        idle_cycles(4);
        rst_n = 1'b1;
        idle_cycles(3 * CPB);
        check("midframe_no_dv", dv_cnt - dv0, 32'd0);
        check("midframe_no_ferr", ferr_cnt - fe0, 32'd0);
        bb = '{data: 8'h7E, stop: 1'b1, exp_dv: 1'b1, exp_ferr: 1'b0};
        run_vec(bb, "after_reset");

`ifdef UART_RX_PARITY_EN
        // 8'h07 has three ones: parity bit 1 is correct, 0 is wrong.
        dv0 = dv_cnt;
        pe0 = perr_cnt;
        send_frame(8'h07, 1'b1, 1'b1);
        idle_cycles(3 * CPB);
        check("parity_bad_perr", perr_cnt - pe0, 32'd1);
        check("parity_bad_no_dv", dv_cnt - dv0, 32'd0);
        check("parity_bad_byte", {24'd0, rx_byte}, {24'd0, last_good});
        dv0 = dv_cnt;
        pe0 = perr_cnt;
        exp_q.push_back(8'h07);
        last_good = 8'h07;
        send_frame(8'h07, 1'b1, 1'b0);
        idle_cycles(3 * CPB);
        check("parity_good_perr", perr_cnt - pe0, 32'd0);
        check("parity_good_dv", dv_cnt - dv0, 32'd1);
        check("parity_good_byte", {24'd0, rx_byte}, 32'h07);
`else
        pe0 = perr_cnt;
        check("no_parity_errs", pe0, 32'd0);
`endif

        check("final_queue_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
